// File: rtl/sync_filter_edge_pkg.sv
// Shared definitions for the sync_filter_edge synchronizer slice.
//   clog2           : ceiling log2 for constant sizing
//   cnt_width       : filter counter width (at least 1 bit)
//   params_ok       : elaboration-time legality check of depth/filter settings
//   SYNC_MIN_STAGES : minimum synchronizer depth
package sync_filter_edge_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // A 1-deep filter needs no counter; keep one bit so the vector is legal.
  function automatic int unsigned cnt_width(input int unsigned filt);
    return (filt > 1) ? clog2(filt) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned stages, input int unsigned filt);
    return (stages >= SYNC_MIN_STAGES) && (filt >= 1);
  endfunction

endpackage

// File: rtl/sync_filter_edge_bit.sv
// One channel of sync_filter_edge: synchronizer chain, stability filter,
// filtered level and registered rise/fall pulses.
//   clk   : clock, posedge
//   rst_n : synchronous active-low reset
//   d     : asynchronous level input
//   q     : synchronized, filtered level
//   rise  : 1-cycle pulse when q goes 0->1
//   fall  : 1-cycle pulse when q goes 1->0
//   upd   : combinational update event (q changes at the coming edge)
module sync_filter_bit
  import sync_filter_edge_pkg::*;
#(
  parameter int unsigned P_STAGES   = 2,
  parameter int unsigned P_FILT_CNT = 4,
  parameter logic        P_RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic upd
);

  localparam int unsigned CW = cnt_width(P_FILT_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(P_FILT_CNT - 1);

  logic [P_STAGES-1:0] sync;
  logic [CW-1:0]       cnt;
  logic                s;

  assign s   = sync[P_STAGES-1];
  // With P_FILT_CNT = 1 the counter stays 0 == CNT_MAX, so q follows s every cycle.
  assign upd = (s != q) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {P_STAGES{P_RST_BIT}};
      q    <= P_RST_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[P_STAGES-2:0], d};
      rise <= upd & s;
      fall <= upd & ~s;
      if (s == q) begin
        cnt <= '0;
      end else if (upd) begin
        q   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-bit level synchronizer with per-bit glitch filter and edge pulses.
//   clk    : clock, posedge
//   rst_n  : synchronous active-low reset
//   i_data : asynchronous level inputs
//   o_data : synchronized, filtered levels
//   o_rise : per-bit 1-cycle pulse on 0->1 of o_data
//   o_fall : per-bit 1-cycle pulse on 1->0 of o_data
//   o_chg  : 1-cycle pulse when any bit of o_rise | o_fall is set
module sync_filter_edge
  import sync_filter_edge_pkg::*;
#(
  parameter int unsigned          P_DATA_W   = 8,
  parameter int unsigned          P_STAGES   = 2,
  parameter int unsigned          P_FILT_CNT = 4,
  parameter logic [P_DATA_W-1:0]  P_RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P_DATA_W-1:0] i_data,
  output logic [P_DATA_W-1:0] o_data,
  output logic [P_DATA_W-1:0] o_rise,
  output logic [P_DATA_W-1:0] o_fall,
  output logic                o_chg
);

  if (!params_ok(P_STAGES, P_FILT_CNT)) begin : g_param_err
    $error("sync_filter_edge: P_STAGES must be >= 2 and P_FILT_CNT >= 1");
  end

  logic [P_DATA_W-1:0] upd;

  for (genvar i = 0; i < P_DATA_W; i++) begin : g_bit
    sync_filter_bit #(
      .P_STAGES   (P_STAGES),
      .P_FILT_CNT (P_FILT_CNT),
      .P_RST_BIT  (P_RST_VAL[i])
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (i_data[i]),
      .q     (o_data[i]),
      .rise  (o_rise[i]),
      .fall  (o_fall[i]),
      .upd   (upd[i])
    );
  end

  // Registered from the same update events that load o_rise/o_fall, so aligned with them.
  always_ff @(posedge clk) begin
    if (!rst_n) o_chg <= 1'b0;
    else        o_chg <= |upd;
  end

endmodule

// File: tb/tb_sync_filter_edge.sv
// Self-checking bench for sync_filter_edge: two configurations driven by the
// same stimulus, each compared every cycle against a sample-window model.
module tb_sync_filter_edge;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_data;
  logic [3:0] a_data, a_rise, a_fall;
  logic       a_chg;
  logic [3:0] b_data, b_rise, b_fall;
  logic       b_chg;

  int total;
  int bad;

  sync_filter_edge #(
    .P_DATA_W   (4),
    .P_STAGES   (2),
    .P_FILT_CNT (3),
    .P_RST_VAL  (4'b0000)
  ) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (i_data),
    .o_data (a_data),
    .o_rise (a_rise),
    .o_fall (a_fall),
    .o_chg  (a_chg)
  );

  sync_filter_edge #(
    .P_DATA_W   (4),
    .P_STAGES   (3),
    .P_FILT_CNT (1),
    .P_RST_VAL  (4'b1010)
  ) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (i_data),
    .o_data (b_data),
    .o_rise (b_rise),
    .o_fall (b_fall),
    .o_chg  (b_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = config A, 1 = config B.
  // o_data flips a bit once the last FILT samples of the synchronized value
  // all differ from the current o_data bit.
  int unsigned stg [2] = '{2, 3};
  int unsigned flt [2] = '{3, 1};
  logic [3:0]  rv  [2] = '{4'b0000, 4'b1010};
  logic [3:0]  sync_m [2][4];
  logic [3:0]  hist_m [2][4];
  logic [3:0]  o_m [2];
  logic [3:0]  r_m [2];
  logic [3:0]  f_m [2];
  logic        c_m [2];

  task automatic model_edge();
    logic [3:0] s;
    logic [3:0] away;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int j = 0; j < 4; j++) begin
          sync_m[k][j] = rv[k];
          hist_m[k][j] = rv[k];
        end
        o_m[k] = rv[k];
        r_m[k] = '0;
        f_m[k] = '0;
        c_m[k] = 1'b0;
      end else begin
        s = sync_m[k][stg[k]-1];
        for (int j = 3; j > 0; j--) hist_m[k][j] = hist_m[k][j-1];
        hist_m[k][0] = s;
        away = '1;
        for (int j = 0; j < int'(flt[k]); j++) away &= hist_m[k][j] ^ o_m[k];
        r_m[k] = away & ~o_m[k];
        f_m[k] = away & o_m[k];
        c_m[k] = |away;
        o_m[k] = o_m[k] ^ away;
        for (int j = 3; j > 0; j--) sync_m[k][j] = sync_m[k][j-1];
        sync_m[k][0] = i_data;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("a_data", a_data, o_m[0]);
    check("a_rise", a_rise, r_m[0]);
    check("a_fall", a_fall, f_m[0]);
    check("a_chg",  {3'b0, a_chg}, {3'b0, c_m[0]});
    check("b_data", b_data, o_m[1]);
    check("b_rise", b_rise, r_m[1]);
    check("b_fall", b_fall, f_m[1]);
    check("b_chg",  {3'b0, b_chg}, {3'b0, c_m[1]});
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    i_data = 4'hF;

    // Reset held with inputs high.
    repeat (3) tick();
    check("rst_a_data", a_data, 4'h0);
    check("rst_a_chg", {3'b0, a_chg}, 4'h0);
    check("rst_b_data", b_data, 4'b1010);
    rst_n = 1'b1;
    tick();                   // capture edge E
    repeat (3) tick();
    tick();                   // E+4
    check("rel_a_data", a_data, 4'hF);
    check("rel_a_rise", a_rise, 4'hF);
    check("rel_a_chg", {3'b0, a_chg}, 4'h1);
    tick();
    check("rel_a_rise_end", a_rise, 4'h0);
    check("rel_a_chg_end", {3'b0, a_chg}, 4'h0);

    // Back to zero, then single-bit latency.
    i_data = 4'h0;
    repeat (8) tick();
    i_data = 4'b0001;
    tick();                   // E
    repeat (3) tick();
    check("lat_early", a_data, 4'h0);
    tick();                   // E+4
    check("lat_data", a_data, 4'b0001);
    check("lat_rise", a_rise, 4'b0001);
    tick();
    check("lat_rise_end", a_rise, 4'h0);

    // Glitch on bit 1: 2 cycles rejected, 3 cycles passes.
    i_data = 4'b0011; repeat (2) tick();
    i_data = 4'b0001; repeat (8) tick();
    check("glitch_rej", a_data, 4'b0001);
    i_data = 4'b0011; repeat (3) tick();
    i_data = 4'b0001; repeat (10) tick();

    // Mixed edges from 0011 to 1100.
    i_data = 4'b0011; repeat (8) tick();
    check("mix_pre", a_data, 4'b0011);
    i_data = 4'b1100;
    tick();
    repeat (3) tick();
    tick();
    check("mix_rise", a_rise, 4'b1100);
    check("mix_fall", a_fall, 4'b0011);
    check("mix_chg", {3'b0, a_chg}, 4'h1);
    repeat (4) tick();

    // Reset during a pending filter count on bit 2.
    i_data = 4'b0000; repeat (8) tick();
    i_data = 4'b0100;
    repeat (3) tick();        // capture, s rises, count reaches 1
    rst_n = 1'b0; tick();
    check("midrst_data", a_data, 4'h0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_hold", a_data, 4'h0);
    tick();
    check("midrst_rise", a_rise, 4'b0100);

    // Bypass configuration exercises.
    i_data = 4'b1010; repeat (6) tick();
    i_data = 4'b0000; repeat (6) tick();

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 3))
        0: i_data = 4'($urandom);
        1: i_data = i_data ^ (4'b0001 << $urandom_range(0, 3));
        default: ;
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_filter_edge.md
Name: sync_filter_edge

Overview:
Multi-bit synchronizer for asynchronous level inputs (pins, status flags from other domains) entering the `clk` domain. It extends the fixed 2-flop synchronizer in three ways:
- configurable synchronizer depth;
- per-bit stability (glitch) filter;
- per-bit registered rising/falling edge pulses.
Each bit is independent. The block sits directly at domain/pin boundaries, feeding control FSMs that need clean levels and single-cycle event strobes.

Parameters:
P_DATA_W, 8, number of independent channels (bits); >= 1
P_STAGES, 2, synchronizer flop depth; >= 2
P_FILT_CNT, 4, consecutive stable cycles required before `o_data` follows; >= 1; 1 = no filtering
P_RST_VAL, {P_DATA_W{1'b0}}, reset value of synchronizer stages and `o_data`

Ports:
clk     input   1         clock; all logic on posedge
rst_n   input   1         reset, synchronous, active-low
i_data  input   P_DATA_W  asynchronous level inputs
o_data  output  P_DATA_W  synchronized, filtered levels (registered)
o_rise  output  P_DATA_W  1-cycle pulse per bit: `o_data` bit just went 0->1
o_fall  output  P_DATA_W  1-cycle pulse per bit: `o_data` bit just went 1->0
o_chg   output  1         1-cycle pulse: any bit of `o_rise | o_fall` set (registered)

Behaviour:
- Reset: one clock; reset is synchronous and active-low (`rst_n` sampled on posedge `clk`).
  - While `rst_n` = 0 at a posedge, on that edge: all sync stages and `o_data` <= P_RST_VAL; filter counters <= 0; `o_rise`, `o_fall`, `o_chg` <= 0.
  - Reset mid-operation aborts any pending filter count; no pulse is produced by reset itself.
- Sync chain: per bit, `P_STAGES` flops. Stage 1 samples `i_data`. `s` is the last stage output. No logic between stages.
- Filter, per bit, with counter `cnt` of width clog2(P_FILT_CNT):
  - `s` == `o_data`: `cnt` <= 0.
  - `s` != `o_data` and `cnt` == P_FILT_CNT-1: `o_data` <= `s`, `cnt` <= 0 (update event).
  - otherwise: `cnt` <= `cnt` + 1.
  - An `s` excursion shorter than P_FILT_CNT cycles never reaches `o_data`. The counter clears on any return to `o_data`. Counts are consecutive, not cumulative.
  - P_FILT_CNT = 1: `cnt` is unused; `o_data` <= `s` every cycle.
- Edges: on an update event, at the same edge as `o_data` changes:
  - `o_rise` bit <= `s`; `o_fall` bit <= ~`s`.
  - Otherwise both bits <= 0.
  - Pulses are therefore visible in the same cycle as the new `o_data` level, exactly 1 cycle wide.
  - `o_rise` and `o_fall` are never both set on the same bit.
- `o_chg` <= OR-reduce of the next-state `o_rise | o_fall`, so it is aligned with them.
- Latency:
  - `i_data` change captured at edge E: `s` changes at edge E+P_STAGES-1.
  - `o_data`, `o_rise`/`o_fall` and `o_chg` change at edge E+P_STAGES+P_FILT_CNT-1.
  - With defaults: 5 edges.
- Simultaneous events:
  - Bits are fully independent; any mix of rises and falls in one cycle is legal.
  - `o_chg` is a single pulse regardless of how many bits change.
- Continuous toggling faster than P_FILT_CNT cycles at `s` holds `o_data` indefinitely. This is intended.
- No handshake; the outputs are free-running.

Decomposition:
- Shared package/header:
  - clog2 function;
  - constant SYNC_MIN_STAGES = 2;
  - elaboration check that fails if P_STAGES < 2 or P_FILT_CNT < 1.
- Sub-module `sync_filter_bit`:
  - one channel: sync chain, filter counter, `o_data` bit, rise/fall bits;
  - parameters P_STAGES, P_FILT_CNT, P_RST_BIT.
- Top instantiates P_DATA_W copies via generate and builds `o_chg`.

Test Plan:
All scenarios use P_DATA_W=4, P_STAGES=2, P_FILT_CNT=3, P_RST_VAL=0 unless stated.
- Reset: hold `rst_n`=0 for 3 cycles with `i_data`=4'hF. Then `o_data`=0 and `o_rise`/`o_fall`/`o_chg`=0. After release, `o_data` becomes 4'hF 4 edges later, with `o_rise`=4'hF and `o_chg`=1 for exactly 1 cycle.
- Latency: `i_data`[0] 0->1 held, first sampled at edge E. Then `o_data`[0]=1 and `o_rise`[0]=1 after edge E+4 only. `o_rise` returns to 0 at E+5. `o_fall` stays 0.
- Glitch reject: `i_data`[1]=1 for 2 cycles, then 0. Then `o_data`[1] stays 0 and no pulses occur. With a 3-cycle excursion instead, `o_data`[1]=1 for 3 cycles, with one `o_rise`[1] pulse and later one `o_fall`[1] pulse.
- Mixed edges: from `o_data`=4'b0011, apply `i_data`=4'b1100. At the update edge, `o_rise`=4'b1100 and `o_fall`=4'b0011 together, and `o_chg`=1 for exactly one cycle.
- Reset mid-count: `i_data`[2] goes 0->1, then `rst_n`=0 at filter count 1 for 1 cycle. Then no pulse occurs and `o_data`[2]=0. After release, `o_data`[2] rises exactly 4 edges later.
- Reset value / bypass: P_RST_VAL=4'b1010, P_FILT_CNT=1, P_STAGES=3. After reset `o_data`=4'b1010. Driving `i_data`=4'b1010 produces no pulses. Driving 4'b0000 sets `o_fall`=4'b1010 exactly 3 edges after capture.
